// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts one branch/jump request, drives the
// shared branch comparator, decodes funct3 into taken/not-taken, returns the
// next fetch PC, holds a pipeline flush after taken redirects and keeps
// branch statistics.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_is_jump,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_target,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  output logic [XLEN-1:0]  cmp_R1,
  output logic [XLEN-1:0]  cmp_R2,
  output logic             cmp_BrUn,
  input  logic             cmp_BrLT,
  input  logic             cmp_BrEQ,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [XLEN-1:0]  resp_pc,
  output logic             resp_illegal,
  output logic             resp_misaligned,
  output logic             flush,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP, FLUSH} stateE;

  // Flush down-counter only needs to hold FLUSH_CYCLES-1.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  stateE           state;
  logic [2:0]      funct3Q;
  logic            isJumpQ;
  logic [XLEN-1:0] pcQ;
  logic [XLEN-1:0] targetQ;
  logic [FCW-1:0]  flushCnt;

  logic            evalTaken;
  logic            evalIllegal;
  logic [XLEN-1:0] evalNextPc;

  // Decode the latched funct3 against the live comparator result.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    evalTaken   = 1'b0;
    evalIllegal = 1'b0;
    if (isJumpQ) begin
      evalTaken = 1'b1;
    end else begin
      case (funct3Q)
        3'b000:  evalTaken   = cmp_BrEQ;
        3'b001:  evalTaken   = !cmp_BrEQ;
        3'b100:  evalTaken   = cmp_BrLT;
        3'b101:  evalTaken   = !cmp_BrLT;
        3'b110:  evalTaken   = cmp_BrLT;
        3'b111:  evalTaken   = !cmp_BrLT;
        default: evalIllegal = 1'b1;
      endcase
    end
    evalNextPc = evalTaken ? targetQ : pcQ + XLEN'(4);
  end

  // Controller FSM with registered handshake, response, flush and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the latched request fields are reset along with the control
      // state because several of them drive outputs with defined reset values.
      state           <= IDLE;
      req_ready       <= 1'b1;
      funct3Q         <= '0;
      isJumpQ         <= 1'b0;
      pcQ             <= '0;
      targetQ         <= '0;
      cmp_R1          <= '0;
      cmp_R2          <= '0;
      cmp_BrUn        <= 1'b0;
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_pc         <= '0;
      resp_illegal    <= 1'b0;
      resp_misaligned <= 1'b0;
      flush           <= 1'b0;
      flushCnt        <= '0;
      stat_branches   <= '0;
      stat_taken      <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3Q   <= req_funct3;
            isJumpQ   <= req_is_jump;
            pcQ       <= req_pc;
            targetQ   <= req_target;
            cmp_R1    <= req_rs1;
            cmp_R2    <= req_rs2;
            cmp_BrUn  <= req_funct3[1];
            req_ready <= 1'b0;
            state     <= EVAL;
          end
        end
        EVAL: begin
          resp_taken      <= evalTaken;
          resp_pc         <= evalNextPc;
          resp_illegal    <= evalIllegal;
          resp_misaligned <= evalTaken && (targetQ[1:0] != 2'b00);
          resp_valid      <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid    <= 1'b0;
            stat_branches <= stat_branches + CNT_W'(1);
            if (resp_taken) stat_taken <= stat_taken + CNT_W'(1);
            if (resp_taken && FLUSH_CYCLES > 0) begin
              flush    <= 1'b1;
              flushCnt <= FCW'(FLUSH_CYCLES - 1);
              state    <= FLUSH;
            end else begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flushCnt == '0) begin
            flush     <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            flushCnt <= flushCnt - FCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized and directed bench for branch_resolve_ctrl with a comparator
// model driving cmp_BrLT/cmp_BrEQ and a request-level reference model.
module tb_branch_resolve_ctrl;

  localparam int XLEN  = 32;
  localparam int FLUSH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic             req_is_jump;
  logic [XLEN-1:0]  req_pc, req_target, req_rs1, req_rs2;
  logic [XLEN-1:0]  cmp_R1, cmp_R2;
  logic             cmp_BrUn, cmp_BrLT, cmp_BrEQ;
  logic             resp_valid, resp_ready, resp_taken;
  logic [XLEN-1:0]  resp_pc;
  logic             resp_illegal, resp_misaligned, flush;
  logic [CNT_W-1:0] stat_branches, stat_taken;

  int vectors = 0;
  int miscompares = 0;

  logic [CNT_W-1:0] mBranches = '0;
  logic [CNT_W-1:0] mTaken = '0;

  typedef struct packed {
    logic        taken;
    logic [31:0] nextPc;
    logic        illegal;
    logic        misaligned;
  } expT;

  branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_is_jump(req_is_jump),
    .req_pc(req_pc), .req_target(req_target),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .cmp_R1(cmp_R1), .cmp_R2(cmp_R2), .cmp_BrUn(cmp_BrUn),
    .cmp_BrLT(cmp_BrLT), .cmp_BrEQ(cmp_BrEQ),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_pc(resp_pc),
    .resp_illegal(resp_illegal), .resp_misaligned(resp_misaligned),
    .flush(flush),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  // Datapath comparator the controller sequences.
  assign cmp_BrEQ = (cmp_R1 == cmp_R2);
  assign cmp_BrLT = cmp_BrUn ? (cmp_R1 < cmp_R2) : ($signed(cmp_R1) < $signed(cmp_R2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural branch semantics computed straight from the operands.
  function automatic expT model(input logic [2:0] f3, input logic j,
                                input logic [31:0] pc, tgt, a, b);
    expT e;
    int signed sa, sb;
    sa = a;
    sb = b;
    e.illegal = 1'b0;
    if (j) e.taken = 1'b1;
    else begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = (sa < sb);
        3'd5: e.taken = (sa >= sb);
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: begin e.taken = 1'b0; e.illegal = 1'b1; end
      endcase
    end
    e.nextPc     = e.taken ? tgt : pc + 32'd4;
    e.misaligned = e.taken && (tgt % 4 != 0);
    return e;
  endfunction

  task automatic checkResetVals();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_taken", resp_taken, 0);
    check("rst_resp_pc", resp_pc, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    check("rst_resp_misaligned", resp_misaligned, 0);
    check("rst_flush", flush, 0);
    check("rst_cmp_R1", cmp_R1, 0);
    check("rst_cmp_R2", cmp_R2, 0);
    check("rst_cmp_BrUn", cmp_BrUn, 0);
    check("rst_stat_branches", stat_branches, 0);
    check("rst_stat_taken", stat_taken, 0);
  endtask

  // Asserts reset between edges; outputs must clear without waiting for clk.
  task automatic doReset();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkResetVals();
    @(negedge clk);
    rst = 1'b0;
    mBranches = '0;
    mTaken = '0;
  endtask

  // abortAt: 0 = run to completion, 1 = reset in EVAL, 2 = reset in FLUSH.
  task automatic runReq(input logic [2:0] f3, input logic j, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b,
                        input int holdCycles, input int abortAt);
    expT e;
    e = model(f3, j, pc, tgt, a, b);
    check("idle_req_ready", req_ready, 1);
    check("idle_flush", flush, 0);
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_is_jump = j;
    req_pc      = pc;
    req_target  = tgt;
    req_rs1     = a;
    req_rs2     = b;
    @(negedge clk);
    req_valid = 1'b0;
    check("eval_req_ready", req_ready, 0);
    check("eval_resp_valid", resp_valid, 0);
    check("eval_cmp_R1", cmp_R1, a);
    check("eval_cmp_R2", cmp_R2, b);
    check("eval_cmp_BrUn", cmp_BrUn, f3[1]);
    if (abortAt == 1) begin
      doReset();
      return;
    end
    @(negedge clk);
    check("resp_valid", resp_valid, 1);
    check("resp_taken", resp_taken, e.taken);
    check("resp_pc", resp_pc, e.nextPc);
    check("resp_illegal", resp_illegal, e.illegal);
    check("resp_misaligned", resp_misaligned, e.misaligned);
    check("resp_req_ready", req_ready, 0);
    for (int i = 0; i < holdCycles; i++) begin
      // Garbage on the request port must be ignored while busy.
      req_valid   = 1'b1;
      req_funct3  = 3'($urandom_range(7));
      req_is_jump = 1'($urandom_range(1));
      req_pc      = $urandom;
      req_target  = $urandom;
      req_rs1     = $urandom;
      req_rs2     = $urandom;
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_taken", resp_taken, e.taken);
      check("hold_pc", resp_pc, e.nextPc);
      check("hold_illegal", resp_illegal, e.illegal);
      check("hold_misaligned", resp_misaligned, e.misaligned);
      check("hold_req_ready", req_ready, 0);
      check("hold_branches", stat_branches, mBranches);
      check("hold_taken_cnt", stat_taken, mTaken);
      check("hold_cmp_R1", cmp_R1, a);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mBranches = mBranches + 1'b1;
    if (e.taken) mTaken = mTaken + 1'b1;
    check("post_resp_valid", resp_valid, 0);
    check("stat_branches", stat_branches, mBranches);
    check("stat_taken", stat_taken, mTaken);
    if (e.taken) begin
      for (int i = 0; i < FLUSH; i++) begin
        check("flush_high", flush, 1);
        check("flush_req_ready", req_ready, 0);
        if (abortAt == 2) begin
          doReset();
          return;
        end
        @(negedge clk);
      end
    end
    check("flush_low", flush, 0);
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    resp_ready  = 1'b0;
    req_funct3  = '0;
    req_is_jump = 1'b0;
    req_pc      = '0;
    req_target  = '0;
    req_rs1     = '0;
    req_rs2     = '0;
    @(negedge clk);
    checkResetVals();
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    runReq(3'b000, 1'b0, 32'h100, 32'h140, 32'h5, 32'h5, 0, 0);
    runReq(3'b100, 1'b0, 32'h200, 32'h300, 32'hFFFF_FFFF, 32'h1, 0, 0);
    runReq(3'b110, 1'b0, 32'h200, 32'h300, 32'hFFFF_FFFF, 32'h1, 0, 0);
    runReq(3'b101, 1'b0, 32'h400, 32'h480, 32'h7, 32'h9, 5, 0);
    runReq(3'b010, 1'b0, 32'h500, 32'h600, 32'h1, 32'h1, 0, 0);
    runReq(3'b011, 1'b0, 32'h500, 32'h600, 32'h1, 32'h2, 0, 0);
    runReq(3'b001, 1'b1, 32'h600, 32'h202, 32'h1, 32'h2, 0, 0);
    runReq(3'b001, 1'b0, 32'hFFFF_FFFC, 32'h10, 32'h3, 32'h3, 0, 0);

    // Reset in EVAL and in FLUSH, each followed by a normal request.
    runReq(3'b000, 1'b0, 32'h700, 32'h740, 32'h5, 32'h5, 0, 1);
    runReq(3'b000, 1'b0, 32'h100, 32'h140, 32'h5, 32'h5, 0, 0);
    runReq(3'b111, 1'b0, 32'h800, 32'h840, 32'h9, 32'h2, 0, 2);
    runReq(3'b100, 1'b0, 32'h900, 32'h944, 32'h3, 32'h2, 0, 0);

    // Counter wrap from a clean reset: 17 not-taken requests.
    @(negedge clk);
    doReset();
    for (int i = 0; i < 17; i++)
      runReq(3'b001, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000, 32'h42, 32'h42, 0, 0);
    check("wrap_branches_const", stat_branches, 4'd1);
    check("wrap_taken_const", stat_taken, 4'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic        j;
      logic [31:0] a, b, pc, tgt;
      f3  = 3'($urandom_range(7));
      j   = ($urandom_range(7) == 0);
      a   = ($urandom_range(1) == 0) ? 32'($urandom_range(15)) : $urandom;
      b   = ($urandom_range(3) == 0) ? a : (($urandom_range(1) == 0) ? 32'($urandom_range(15)) : $urandom);
      pc  = $urandom & 32'hFFFF_FFFC;
      tgt = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      runReq(f3, j, pc, tgt, a, b, $urandom_range(3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
